// File: rtl/booth_pkg.sv
// Shared types and helpers for booth multiplier downstream stages.
// Imported by the accumulator and any future MAC stages.
package booth_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  function automatic int acc_width(
    input int l_word,
    input int n_terms
  );
    return 2 * l_word + $clog2(n_terms) + 1;
  endfunction

  // Sign-extend the low pw bits of p to the full 64-bit word.
  function automatic logic [63:0] sext_product(
    input logic [63:0] p,
    input int unsigned pw
  );
    logic [63:0] m;
    m = ~64'd0 << pw;
    return p[pw-1] ? (p | m) : (p & ~m);
  endfunction

endpackage

// File: rtl/ready_edge_detect.sv
// Rising-edge detector on the multiplier ready line.
// ready_q resets high so an idle-high ready is never a capture.
module ready_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_ready,
  output logic o_cap
);

  logic r_ready_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ready_q <= 1'b1;
    else        r_ready_q <= i_ready;
  end

  assign o_cap = i_ready & ~r_ready_q;

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums n_terms signed products from the booth multiplier and
// hands the sum downstream with a valid/ack handshake.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int l_word  = 4,
  parameter int n_terms = 4,
  localparam int ACC_W  = acc_width(l_word, n_terms),
  localparam int CW     = $clog2(n_terms) + 1,
  localparam int PW     = 2 * l_word
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PW-1:0]    product,
  input  logic             mult_ready,
  input  logic             clear,
  output logic             accept,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ack,
  output logic [CW-1:0]    term_count,
  output logic             overrun
);

  localparam logic [CW-1:0] LAST = CW'(n_terms - 1);

  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic             r_sum_valid;
  logic [CW-1:0]    r_count;
  logic             r_overrun;
  logic             r_accept;

  logic             w_cap;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_next;

  ready_edge_detect u_edge (
    .clock   (clock),
    .reset   (reset),
    .i_ready (mult_ready),
    .o_cap   (w_cap)
  );

  assign w_ext  = ACC_W'(sext_product(64'(product), PW));
  assign w_next = r_acc + w_ext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_accept    <= 1'b1;
    end else if (clear) begin
      // Abort wins over any capture or ack on this edge.
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_sum_valid <= 1'b0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_accept    <= 1'b1;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_cap) begin
            if (r_count == LAST) begin
              r_sum       <= w_next;
              r_sum_valid <= 1'b1;
              r_acc       <= '0;
              r_count     <= '0;
              r_state     <= HOLD;
              r_accept    <= 1'b0;
            end else begin
              r_acc   <= w_next;
              r_count <= r_count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_cap) r_overrun <= 1'b1;
          if (sum_ack) begin
            r_sum_valid <= 1'b0;
            r_state     <= ACCUM;
            r_accept    <= 1'b1;
          end
        end
        default: begin
          r_state  <= ACCUM;
          r_accept <= 1'b1;
        end
      endcase
    end
  end

  assign accept     = r_accept;
  assign sum        = r_sum;
  assign sum_valid  = r_sum_valid;
  assign term_count = r_count;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed self-checking bench for booth_product_accumulator
// with l_word=4, n_terms=4 (ACC_W=11).
module tb_booth_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  prod;
  logic        mrdy;
  logic        clr;
  logic        acc_ok;
  logic [10:0] sum;
  logic        sval;
  logic        sack;
  logic [2:0]  tcnt;
  logic        ovr;

  int n_cmp;
  int n_bad;

  booth_product_accumulator #(
    .l_word  (4),
    .n_terms (4)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .product    (prod),
    .mult_ready (mrdy),
    .clear      (clr),
    .accept     (acc_ok),
    .sum        (sum),
    .sum_valid  (sval),
    .sum_ack    (sack),
    .term_count (tcnt),
    .overrun    (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // One ready 0->1 pulse; the capture edge falls inside.
  task automatic pulse(input logic [7:0] p);
    @(negedge clk);
    prod = p;
    mrdy = 1'b1;
    @(negedge clk);
    mrdy = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    prod  = 8'h00;
    mrdy  = 1'b1;
    clr   = 1'b0;
    sack  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_sum",    32'(sum),    32'h0);
    chk("rst_valid",  32'(sval),   32'h0);
    chk("rst_count",  32'(tcnt),   32'h0);
    chk("rst_ovr",    32'(ovr),    32'h0);
    chk("rst_accept", 32'(acc_ok), 32'h1);

    // ready high out of reset is not a capture
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_high_nocap", 32'(tcnt), 32'h0);
    mrdy = 1'b0;

    pulse(8'h06);
    pulse(8'hFA);
    pulse(8'h31);
    chk("mid_count",  32'(tcnt),   32'h3);
    chk("mid_accept", 32'(acc_ok), 32'h1);
    chk("mid_valid",  32'(sval),   32'h0);
    pulse(8'h40);
    chk("s1_sum",    32'(sum),    32'h071);
    chk("s1_valid",  32'(sval),   32'h1);
    chk("s1_count",  32'(tcnt),   32'h0);
    chk("s1_accept", 32'(acc_ok), 32'h0);

    // product during HOLD is dropped
    pulse(8'h05);
    chk("ovr_set",   32'(ovr),  32'h1);
    chk("ovr_sum",   32'(sum),  32'h071);
    chk("ovr_count", 32'(tcnt), 32'h0);
    chk("ovr_valid", 32'(sval), 32'h1);

    @(negedge clk);
    sack = 1'b1;
    @(negedge clk);
    sack = 1'b0;
    chk("ack_valid",  32'(sval),   32'h0);
    chk("ack_accept", 32'(acc_ok), 32'h1);
    chk("ack_ovr",    32'(ovr),    32'h1);

    // ready held high for 20 cycles
    @(negedge clk);
    prod = 8'h03;
    mrdy = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_count", 32'(tcnt), 32'h1);
    mrdy = 1'b0;

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_count", 32'(tcnt), 32'h0);
    chk("clr_ovr",   32'(ovr),  32'h0);

    pulse(8'h01);
    pulse(8'h02);
    chk("pre_clr_count", 32'(tcnt), 32'h2);
    @(negedge clk);
    clr  = 1'b1;
    prod = 8'h07;
    mrdy = 1'b1;
    @(negedge clk);
    clr  = 1'b0;
    mrdy = 1'b0;
    chk("clr_cap_count", 32'(tcnt), 32'h0);

    repeat (4) pulse(8'hC0);
    chk("s2_sum",   32'(sum),  32'h700);
    chk("s2_valid", 32'(sval), 32'h1);
    chk("s2_count", 32'(tcnt), 32'h0);

    // ack held high: each sum lasts exactly one cycle
    sack = 1'b1;
    @(negedge clk);
    chk("s2_taken", 32'(sval), 32'h0);
    pulse(8'h0A);
    pulse(8'h14);
    pulse(8'h1E);
    pulse(8'h28);
    chk("s3_sum",   32'(sum),  32'h064);
    chk("s3_valid", 32'(sval), 32'h1);
    @(negedge clk);
    chk("s3_one_cycle", 32'(sval),   32'h0);
    chk("s3_accept",    32'(acc_ok), 32'h1);
    sack = 1'b0;

    repeat (4) pulse(8'h01);
    chk("s4_sum",   32'(sum),  32'h004);
    chk("s4_valid", 32'(sval), 32'h1);

    // async reset mid-cycle in HOLD
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(sval),   32'h0);
    chk("arst_sum",    32'(sum),    32'h0);
    chk("arst_count",  32'(tcnt),   32'h0);
    chk("arst_accept", 32'(acc_ok), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_accept", 32'(acc_ok), 32'h1);
    chk("post_rst_valid",  32'(sval),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
